// File: rtl/trap_controller_if.sv
// trap_controller_if
// Bundles every signal between the trap sequencer and its neighbours:
// writeback reports (exc_*, ret_*), interrupt state (irq_lines, mie_csr,
// mstatus_mie, cur_priv), CSR values (mtvec/xepc), pipeline status and
// fetch handshake (pipe_empty, redirect_*), and the privilege block
// requests (handle_*, save_*, exception_code).
// Modports:
//   master : the trap controller (drives flush/stall/handle/redirect outputs)
//   slave  : the surrounding core / testbench (drives reports and CSR values)
interface trap_controller_if #(
  parameter int REG_WIDTH = 64
);
  logic                 exc_valid;
  logic [REG_WIDTH-1:0] exc_pc;
  logic [REG_WIDTH-2:0] exc_code;
  logic [1:0]           cur_priv;
  logic [2:0]           irq_lines;
  logic [REG_WIDTH-1:0] mie_csr;
  logic                 mstatus_mie;
  logic [REG_WIDTH-1:0] retire_pc;
  logic                 ret_valid;
  logic [1:0]           ret_kind;
  logic [REG_WIDTH-1:0] mtvec_csr;
  logic [REG_WIDTH-1:0] mepc_csr;
  logic [REG_WIDTH-1:0] sepc_csr;
  logic [REG_WIDTH-1:0] uepc_csr;
  logic                 pipe_empty;
  logic                 redirect_ready;

  logic                 flush;
  logic                 stall_fetch;
  logic                 handle_interrupt;
  logic                 handle_exception;
  logic                 handle_mret;
  logic                 handle_sret;
  logic                 handle_uret;
  logic [REG_WIDTH-1:0] save_pc;
  logic [1:0]           save_priv;
  logic [REG_WIDTH-2:0] exception_code;
  logic                 redirect_valid;
  logic [REG_WIDTH-1:0] redirect_pc;
  logic                 busy;
  logic                 drain_timeout;

  modport master (
    input  exc_valid, exc_pc, exc_code, cur_priv, irq_lines, mie_csr,
           mstatus_mie, retire_pc, ret_valid, ret_kind, mtvec_csr,
           mepc_csr, sepc_csr, uepc_csr, pipe_empty, redirect_ready,
    output flush, stall_fetch, handle_interrupt, handle_exception,
           handle_mret, handle_sret, handle_uret, save_pc, save_priv,
           exception_code, redirect_valid, redirect_pc, busy, drain_timeout
  );

  modport slave (
    output exc_valid, exc_pc, exc_code, cur_priv, irq_lines, mie_csr,
           mstatus_mie, retire_pc, ret_valid, ret_kind, mtvec_csr,
           mepc_csr, sepc_csr, uepc_csr, pipe_empty, redirect_ready,
    input  flush, stall_fetch, handle_interrupt, handle_exception,
           handle_mret, handle_sret, handle_uret, save_pc, save_priv,
           exception_code, redirect_valid, redirect_pc, busy, drain_timeout
  );
endinterface

// File: rtl/trap_controller.sv
// trap_controller
// Trap sequencer in front of the privilege CSR block. In IDLE it picks one
// event (exception > enabled interrupt > xRET), flushes younger instructions,
// drains the pipeline (bounded by DRAIN_TIMEOUT), issues a one-cycle handle_*
// pulse with save_pc/save_priv/exception_code, then redirects fetch.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : trap_controller_if master modport (all reports, CSRs, handshakes)
module trap_controller #(
  parameter int REG_WIDTH     = 64,
  parameter int DRAIN_TIMEOUT = 15
) (
  input logic            clk,
  input logic            reset,
  trap_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [2:0] {KIND_NONE, KIND_INT, KIND_EXC, KIND_MRET, KIND_SRET, KIND_URET} kind_t;

  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DRAIN_TIMEOUT - 1);

  state_t               state, state_next;
  kind_t                kind_q, event_kind;
  logic [REG_WIDTH-2:0] code_q, event_code;
  logic [REG_WIDTH-1:0] pc_q, event_pc;
  logic [1:0]           priv_q;
  logic [CW-1:0]        count_q;
  logic [REG_WIDTH-1:0] redirect_pc_q, target_pc;
  logic                 drain_timeout_q;
  logic                 event_valid;
  logic                 forced_exit;

  logic [2:0] irq_pending;
  logic       irq_global;

  logic                 flush_c, stall_c, redirect_valid_c;
  logic                 h_int, h_exc, h_mret, h_sret, h_uret;
  logic [REG_WIDTH-1:0] save_pc_c, redirect_pc_c;
  logic [1:0]           save_priv_c;
  logic [REG_WIDTH-2:0] code_c;

  logic unused_mie_bits;
  assign unused_mie_bits = ^{bus.mie_csr[REG_WIDTH-1:12], bus.mie_csr[10:8],
                             bus.mie_csr[6:4], bus.mie_csr[2:0]};

  // Interrupts below M-mode are always taken; in M-mode only with MIE set.
  assign irq_global  = bus.mstatus_mie | (bus.cur_priv != 2'd3);
  assign irq_pending = irq_global ?
                       (bus.irq_lines & {bus.mie_csr[11], bus.mie_csr[7], bus.mie_csr[3]}) :
                       3'b000;

  // Event selection; only consulted while IDLE.
  always_comb begin
    event_valid = 1'b0;
    event_kind  = KIND_NONE;
    event_code  = '0;
    event_pc    = '0;
    if (bus.exc_valid) begin
      event_valid = 1'b1;
      event_kind  = KIND_EXC;
      event_code  = bus.exc_code;
      event_pc    = bus.exc_pc;
    end else if (|irq_pending) begin
      event_valid = 1'b1;
      event_kind  = KIND_INT;
      event_pc    = bus.retire_pc;
      if (irq_pending[2])      event_code = (REG_WIDTH-1)'(11);
      else if (irq_pending[0]) event_code = (REG_WIDTH-1)'(3);
      else                     event_code = (REG_WIDTH-1)'(7);
    end else if (bus.ret_valid && bus.ret_kind != 2'b00) begin
      event_valid = 1'b1;
      event_pc    = bus.retire_pc;
      case (bus.ret_kind)
        2'b01:   event_kind = KIND_MRET;
        2'b10:   event_kind = KIND_SRET;
        default: event_kind = KIND_URET;
      endcase
    end
  end

  // Fetch target computed from CSRs as they stand during COMMIT.
  // Vectored mode adds 4*cause for interrupts only, wrapping at 64 bits.
  always_comb begin
    logic [REG_WIDTH-1:0] base;
    logic [REG_WIDTH-1:0] code_ext;
    base      = {bus.mtvec_csr[REG_WIDTH-1:2], 2'b00};
    code_ext  = {1'b0, code_q};
    target_pc = base;
    case (kind_q)
      KIND_INT:  if (bus.mtvec_csr[1:0] == 2'b01) target_pc = base + (code_ext << 2);
      KIND_MRET: target_pc = bus.mepc_csr;
      KIND_SRET: target_pc = bus.sepc_csr;
      KIND_URET: target_pc = bus.uepc_csr;
      default:   target_pc = base;
    endcase
  end

  // Next-state and output decode; every output is zero unless its state drives it.
  always_comb begin
    state_next       = state;
    forced_exit      = 1'b0;
    flush_c          = 1'b0;
    stall_c          = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = '0;
    h_int            = 1'b0;
    h_exc            = 1'b0;
    h_mret           = 1'b0;
    h_sret           = 1'b0;
    h_uret           = 1'b0;
    save_pc_c        = '0;
    save_priv_c      = 2'b00;
    code_c           = '0;
    case (state)
      IDLE: begin
        if (event_valid) begin
          flush_c    = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        stall_c = 1'b1;
        if (bus.pipe_empty) begin
          state_next = COMMIT;
        end else if (count_q == LAST_COUNT) begin
          state_next  = COMMIT;
          forced_exit = 1'b1;
        end
      end
      COMMIT: begin
        stall_c     = 1'b1;
        h_int       = (kind_q == KIND_INT);
        h_exc       = (kind_q == KIND_EXC);
        h_mret      = (kind_q == KIND_MRET);
        h_sret      = (kind_q == KIND_SRET);
        h_uret      = (kind_q == KIND_URET);
        save_pc_c   = pc_q;
        save_priv_c = priv_q;
        code_c      = code_q;
        state_next  = REDIRECT;
      end
      REDIRECT: begin
        stall_c          = 1'b1;
        redirect_valid_c = 1'b1;
        redirect_pc_c    = redirect_pc_q;
        if (bus.redirect_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus the per-trap latches and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      kind_q          <= KIND_NONE;
      code_q          <= '0;
      pc_q            <= '0;
      priv_q          <= 2'b00;
      count_q         <= '0;
      redirect_pc_q   <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && event_valid) begin
        kind_q  <= event_kind;
        code_q  <= event_code;
        pc_q    <= event_pc;
        priv_q  <= bus.cur_priv;
        count_q <= '0;
      end
      if (state == DRAIN) count_q <= count_q + 1'b1;
      if (forced_exit) drain_timeout_q <= 1'b1;
      if (state == COMMIT) redirect_pc_q <= target_pc;
    end
  end

  assign bus.flush            = flush_c;
  assign bus.stall_fetch      = stall_c;
  assign bus.handle_interrupt = h_int;
  assign bus.handle_exception = h_exc;
  assign bus.handle_mret      = h_mret;
  assign bus.handle_sret      = h_sret;
  assign bus.handle_uret      = h_uret;
  assign bus.save_pc          = save_pc_c;
  assign bus.save_priv        = save_priv_c;
  assign bus.exception_code   = code_c;
  assign bus.redirect_valid   = redirect_valid_c;
  assign bus.redirect_pc      = redirect_pc_c;
  assign bus.busy             = (state != IDLE);
  assign bus.drain_timeout    = drain_timeout_q;

endmodule
